// File: rtl/fetch_stage.sv
// fetch_stage: MIPS instruction fetch stage with PC, imem req/gnt/rvalid handshake and instruction buffer
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   imem_req/addr       fetch request and word-aligned byte address (held until gnt)
//   imem_gnt            memory accepted the request this cycle
//   imem_rvalid/rdata   returned instruction word (honoured only while waiting)
//   redirect/pc         taken branch/jump: flush buffer, drop in-flight fetch, restart at redirect_pc
//   id_valid/ready      head-of-buffer handshake to decode
//   id_instr/pc/pcplus4 head instruction, its address and address+4 (instr/pc are 0 when empty)
//   opcode              id_instr[31:26] for the main decoder
// Optional: define FETCH_PERF_CNT_EN to add saturating stall_cycles and dropped_resp counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pcplus4,
    output logic [5:0]  opcode
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [15:0] dropped_resp
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
    typedef enum logic {REQ, WAIT} state_t;
    state_t        state, state_nxt;
    logic [31:0]   pc, pc_nxt, req_pc, req_pc_nxt;
    logic          drop, drop_nxt;
    logic [AW:0]   count;
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [31:0]   buf_pc    [FIFO_DEPTH];
    logic [31:0]   buf_instr [FIFO_DEPTH];
    logic          issue, resp, push, pop;
    assign imem_req   = !reset && state == REQ && count < FULL;
    assign imem_addr  = pc;
    assign id_valid   = count != '0;
    assign id_instr   = id_valid ? buf_instr[rd_ptr] : 32'h0;
    assign id_pc      = id_valid ? buf_pc[rd_ptr] : 32'h0;
    assign id_pcplus4 = id_pc + 32'd4;
    assign opcode     = id_instr[31:26];
    always_comb begin
        issue      = imem_req && imem_gnt;
        resp       = state == WAIT && imem_rvalid;
        // a response is kept only if no redirect has superseded its request
        push       = resp && !drop && !redirect;
        pop        = id_valid && id_ready;
        state_nxt  = state;
        pc_nxt     = pc;
        req_pc_nxt = req_pc;
        drop_nxt   = drop;
        if (state == REQ) begin
            if (issue) begin
                state_nxt  = WAIT;
                req_pc_nxt = pc;
                pc_nxt     = pc + 32'd4;
                drop_nxt   = redirect;
            end
        end else if (resp) begin
            state_nxt = REQ;
            drop_nxt  = 1'b0;
        end else if (redirect) begin
            drop_nxt = 1'b1;
        end
        if (redirect)
            pc_nxt = redirect_pc & ~32'h3;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= REQ;
            pc     <= RESET_PC;
            req_pc <= 32'h0;
            drop   <= 1'b0;
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            state  <= state_nxt;
            pc     <= pc_nxt;
            req_pc <= req_pc_nxt;
            drop   <= drop_nxt;
            if (redirect) begin
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push && !pop)
                    count <= count + (AW+1)'(1);
                else if (pop && !push)
                    count <= count - (AW+1)'(1);
                if (pop)
                    rd_ptr <= rd_ptr + AW'(1);
                if (push)
                    wr_ptr <= wr_ptr + AW'(1);
            end
        end
    end
    // buffer storage needs no reset: entries are only read while count says they are valid
    always_ff @(posedge clk) begin
        if (push) begin
            buf_pc[wr_ptr]    <= req_pc;
            buf_instr[wr_ptr] <= imem_rdata;
        end
    end
`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= 32'h0;
            dropped_resp <= 16'h0;
        end else begin
            if (id_ready && !id_valid && stall_cycles != '1)
                stall_cycles <= stall_cycles + 32'd1;
            if (resp && (drop || redirect) && dropped_resp != '1)
                dropped_resp <= dropped_resp + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: self-checking bench for fetch_stage (directed scenarios plus randomized run against a queue model)
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic        imem_gnt, imem_rvalid, redirect, id_ready;
    logic [31:0] imem_rdata, redirect_pc;
    logic        imem_req, id_valid, w_imem_req, w_id_valid;
    logic [31:0] imem_addr, id_instr, id_pc, id_pcplus4;
    logic [31:0] w_imem_addr, w_id_instr, w_id_pc, w_id_pcplus4;
    logic [5:0]  opcode, w_opcode;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cycles, w_stall_cycles;
    logic [15:0] dropped_resp, w_dropped_resp;
`endif
    int          errors = 0;
    int          checks = 0;
    logic        mem_pend;
    logic [31:0] mem_a;
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    fetch_stage dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr),
        .id_pc(id_pc), .id_pcplus4(id_pcplus4), .opcode(opcode)
`ifdef FETCH_PERF_CNT_EN
        , .stall_cycles(stall_cycles), .dropped_resp(dropped_resp)
`endif
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) dut_w (
        .clk(clk), .reset(reset),
        .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .id_valid(w_id_valid), .id_ready(id_ready), .id_instr(w_id_instr),
        .id_pc(w_id_pc), .id_pcplus4(w_id_pcplus4), .opcode(w_opcode)
`ifdef FETCH_PERF_CNT_EN
        , .stall_cycles(w_stall_cycles), .dropped_resp(w_dropped_resp)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
    endfunction

    task automatic drive(input logic g, input logic r, input logic rd, input logic [31:0] rpc, input logic rv);
        imem_gnt    = g;
        id_ready    = r;
        redirect    = rd;
        redirect_pc = rpc;
        imem_rvalid = mem_pend && rv;
        imem_rdata  = mem_pend ? word(mem_a) : 32'h0;
        #1;
    endtask

    task automatic advance();
        if (imem_req && imem_gnt) begin
            mem_pend = 1'b1;
            mem_a    = imem_addr;
        end else if (imem_rvalid) begin
            mem_pend = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0; redirect = 0; redirect_pc = 0; id_ready = 0;
        mem_pend = 1'b0;
        mem_a = 32'h0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0; redirect = 0; redirect_pc = 0; id_ready = 0;
        mem_pend = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", imem_req); end
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", id_valid); end
        checks++; if (id_instr !== 32'h0) begin errors++; $display("FAIL reset_instr got=%h exp=0", id_instr); end
        checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=0", id_pc); end
        checks++; if (opcode !== 6'h0) begin errors++; $display("FAIL reset_opcode got=%h exp=0", opcode); end
        @(negedge clk);
        reset = 1'b0;
        drive(1, 0, 0, 0, 1);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL reset_first_req got=%b/%h exp=1/00000000", imem_req, imem_addr); end
        advance();
        reset = 1'b1;
        mem_pend = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_mid_req got=%b exp=0", imem_req); end
        @(negedge clk);
        reset = 1'b0;
        imem_gnt = 0; id_ready = 0; imem_rvalid = 1; imem_rdata = 32'hDEAD_BEEF;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL reset_restart got=%b/%h exp=1/00000000", imem_req, imem_addr); end
        @(negedge clk);
        imem_rvalid = 0;
        #1;
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_stale_rvalid got=%b exp=0", id_valid); end
`ifdef FETCH_PERF_CNT_EN
        checks++; if (stall_cycles !== 32'h0 || dropped_resp !== 16'h0) begin errors++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", stall_cycles, dropped_resp); end
`endif
        @(negedge clk);
    endtask

    task automatic test_zero_wait();
        logic [31:0] w;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            drive(1, 1, 0, 0, 1);
            checks++; if (imem_req !== 1'(c % 2 == 0)) begin errors++; $display("FAIL zw_req c=%0d got=%b", c, imem_req); end
            if (c % 2 == 0) begin
                checks++; if (imem_addr !== 32'(2 * c)) begin errors++; $display("FAIL zw_addr c=%0d got=%h exp=%h", c, imem_addr, 32'(2 * c)); end
            end
            checks++; if (id_valid !== 1'(c >= 2 && c % 2 == 0)) begin errors++; $display("FAIL zw_valid c=%0d got=%b", c, id_valid); end
            if (c >= 2 && c % 2 == 0) begin
                w = word(32'(2 * c - 4));
                checks++; if (id_pc !== 32'(2 * c - 4)) begin errors++; $display("FAIL zw_pc c=%0d got=%h exp=%h", c, id_pc, 32'(2 * c - 4)); end
                checks++; if (id_instr !== w) begin errors++; $display("FAIL zw_instr c=%0d got=%h exp=%h", c, id_instr, w); end
                checks++; if (opcode !== w[31:26]) begin errors++; $display("FAIL zw_opcode c=%0d got=%h exp=%h", c, opcode, w[31:26]); end
                checks++; if (id_pcplus4 !== 32'(2 * c)) begin errors++; $display("FAIL zw_pcplus4 c=%0d got=%h exp=%h", c, id_pcplus4, 32'(2 * c)); end
            end
            advance();
        end
`ifdef FETCH_PERF_CNT_EN
        #1;
        checks++; if (stall_cycles !== 32'd5) begin errors++; $display("FAIL zw_stall got=%0d exp=5", stall_cycles); end
`endif
    endtask

    task automatic test_full();
        bit er[10] = '{1, 0, 1, 0, 0, 0, 0, 1, 0, 1};
        int ea[10] = '{0, 0, 4, 0, 0, 0, 0, 8, 0, 12};
        bit ev[10] = '{0, 0, 1, 1, 1, 1, 1, 1, 0, 1};
        int ep[10] = '{0, 0, 0, 0, 0, 0, 0, 4, 0, 8};
        do_reset();
        for (int c = 0; c < 10; c++) begin
            drive(1, 1'(c >= 6), 0, 0, 1);
            checks++; if (imem_req !== er[c]) begin errors++; $display("FAIL full_req c=%0d got=%b exp=%b", c, imem_req, er[c]); end
            if (er[c]) begin
                checks++; if (imem_addr !== 32'(ea[c])) begin errors++; $display("FAIL full_addr c=%0d got=%h exp=%h", c, imem_addr, 32'(ea[c])); end
            end
            checks++; if (id_valid !== ev[c]) begin errors++; $display("FAIL full_valid c=%0d got=%b exp=%b", c, id_valid, ev[c]); end
            if (ev[c]) begin
                checks++; if (id_pc !== 32'(ep[c]) || id_instr !== word(32'(ep[c]))) begin errors++; $display("FAIL full_head c=%0d got=%h/%h exp=%h/%h", c, id_pc, id_instr, 32'(ep[c]), word(32'(ep[c]))); end
            end
            advance();
        end
    endtask

    task automatic test_redirect_wait();
        do_reset();
        drive(1, 1, 0, 0, 1);
        advance();
        drive(0, 1, 1, 32'h0000_0103, 0);
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rw_req_wait got=%b exp=0", imem_req); end
        advance();
        drive(0, 1, 0, 0, 1);
        checks++; if (imem_req !== 1'b0 || id_valid !== 1'b0) begin errors++; $display("FAIL rw_pending got=%b/%b exp=0/0", imem_req, id_valid); end
        advance();
        drive(1, 1, 0, 0, 1);
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rw_dropped got=%b exp=0", id_valid); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0100) begin errors++; $display("FAIL rw_newaddr got=%b/%h exp=1/00000100", imem_req, imem_addr); end
`ifdef FETCH_PERF_CNT_EN
        checks++; if (dropped_resp !== 16'd1) begin errors++; $display("FAIL rw_dropcnt got=%0d exp=1", dropped_resp); end
`endif
        advance();
        drive(0, 0, 0, 0, 1);
        advance();
        drive(0, 0, 0, 0, 1);
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'h0000_0100 || id_instr !== word(32'h100)) begin errors++; $display("FAIL rw_refetch got=%b/%h/%h exp=1/00000100/%h", id_valid, id_pc, id_instr, word(32'h100)); end
        advance();
    endtask

    task automatic test_redirect_gnt_pop();
        do_reset();
        drive(1, 0, 0, 0, 1);
        advance();
        drive(0, 0, 0, 0, 1);
        advance();
        drive(1, 1, 1, 32'h0000_0200, 1);
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_instr !== word(32'h0)) begin errors++; $display("FAIL rg_pop got=%b/%h/%h exp=1/00000000/%h", id_valid, id_pc, id_instr, word(32'h0)); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin errors++; $display("FAIL rg_req got=%b/%h exp=1/00000004", imem_req, imem_addr); end
        advance();
        drive(0, 0, 0, 0, 1);
        checks++; if (id_valid !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL rg_flush got=%b/%b exp=0/0", id_valid, imem_req); end
        advance();
        drive(1, 0, 0, 0, 1);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0200 || id_valid !== 1'b0) begin errors++; $display("FAIL rg_refetch got=%b/%h/%b exp=1/00000200/0", imem_req, imem_addr, id_valid); end
`ifdef FETCH_PERF_CNT_EN
        checks++; if (dropped_resp !== 16'd1) begin errors++; $display("FAIL rg_dropcnt got=%0d exp=1", dropped_resp); end
`endif
        advance();
        drive(0, 0, 0, 0, 1);
        advance();
        drive(0, 0, 0, 0, 0);
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'h0000_0200 || id_instr !== word(32'h200)) begin errors++; $display("FAIL rg_deliver got=%b/%h/%h exp=1/00000200/%h", id_valid, id_pc, id_instr, word(32'h200)); end
        advance();
    endtask

    task automatic test_wrap();
        logic [31:0] ea, ep;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            drive(1, 1, 0, 0, 1);
            if (c % 2 == 0) begin
                ea = 32'hFFFF_FFF8 + 32'(2 * c);
                checks++; if (w_imem_req !== 1'b1 || w_imem_addr !== ea) begin errors++; $display("FAIL wrap_addr c=%0d got=%b/%h exp=1/%h", c, w_imem_req, w_imem_addr, ea); end
            end
            if (c >= 2 && c % 2 == 0) begin
                ep = 32'hFFFF_FFF8 + 32'(2 * c - 4);
                checks++; if (w_id_valid !== 1'b1 || w_id_pc !== ep) begin errors++; $display("FAIL wrap_pc c=%0d got=%b/%h exp=1/%h", c, w_id_valid, w_id_pc, ep); end
                checks++; if (w_id_pcplus4 !== ep + 32'd4) begin errors++; $display("FAIL wrap_pcplus4 c=%0d got=%h exp=%h", c, w_id_pcplus4, ep + 32'd4); end
            end
            advance();
        end
    endtask

    task automatic test_random();
        ent_t        q[$];
        logic [31:0] m_pc = 32'h0, m_req_pc = 32'h0;
        logic        m_busy = 0, m_drop = 0;
        logic        e_req, e_valid, issued, resp, g, r, rd;
        logic [31:0] e_instr, e_pc, rpc;
        logic [5:0]  e_op;
        longint      m_stall = 0, m_drops = 0;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            g   = ($urandom % 10) < 6;
            r   = ($urandom % 10) < 7;
            rd  = ($urandom % 20) == 0;
            rpc = ($urandom % 4 == 0) ? (32'hFFFF_FFF0 | ($urandom % 16)) : $urandom;
            imem_gnt    = g;
            id_ready    = r;
            redirect    = rd;
            redirect_pc = rpc;
            imem_rvalid = mem_pend ? 1'($urandom % 2) : 1'($urandom % 10 == 0);
            imem_rdata  = mem_pend ? word(mem_a) : $urandom;
            #1;
            e_req   = !m_busy && q.size() < 2;
            e_valid = q.size() != 0;
            e_instr = e_valid ? q[0].instr : 32'h0;
            e_pc    = e_valid ? q[0].pc : 32'h0;
            e_op    = e_instr[31:26];
            checks++; if (imem_req !== e_req) begin errors++; $display("FAIL rnd_req c=%0d got=%b exp=%b", c, imem_req, e_req); end
            if (e_req) begin
                checks++; if (imem_addr !== m_pc) begin errors++; $display("FAIL rnd_addr c=%0d got=%h exp=%h", c, imem_addr, m_pc); end
            end
            checks++; if (id_valid !== e_valid) begin errors++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, id_valid, e_valid); end
            checks++; if (id_instr !== e_instr || opcode !== e_op) begin errors++; $display("FAIL rnd_instr c=%0d got=%h/%h exp=%h/%h", c, id_instr, opcode, e_instr, e_op); end
            checks++; if (id_pc !== e_pc || id_pcplus4 !== e_pc + 32'd4) begin errors++; $display("FAIL rnd_pc c=%0d got=%h/%h exp=%h/%h", c, id_pc, id_pcplus4, e_pc, e_pc + 32'd4); end
`ifdef FETCH_PERF_CNT_EN
            checks++; if (stall_cycles !== 32'(m_stall) || dropped_resp !== 16'(m_drops)) begin errors++; $display("FAIL rnd_counters c=%0d got=%0d/%0d exp=%0d/%0d", c, stall_cycles, dropped_resp, m_stall, m_drops); end
`endif
            issued = e_req && g;
            resp   = m_busy && imem_rvalid;
            if (r && !e_valid && m_stall < 64'hFFFF_FFFF) m_stall++;
            if (resp && (m_drop || rd) && m_drops < 64'hFFFF) m_drops++;
            if (r && e_valid) void'(q.pop_front());
            if (resp && !m_drop && !rd) q.push_back('{pc: m_req_pc, instr: imem_rdata});
            if (rd) q.delete();
            if (issued) begin
                m_busy = 1; m_req_pc = m_pc; m_drop = rd;
            end else if (resp) begin
                m_busy = 0; m_drop = 0;
            end else if (m_busy && rd) begin
                m_drop = 1;
            end
            m_pc = rd ? (rpc & ~32'h3) : issued ? m_pc + 32'd4 : m_pc;
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_full();
        test_redirect_wait();
        test_redirect_gnt_pop();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
